// File: rtl/riscv_fetch_buffer_if.sv
// Fetch-buffer bus: instruction-memory request/response, core delivery handshake and redirect.
// master = fetch buffer, slave = memory/core side.
interface riscv_fetch_buffer_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] instruct;
  logic [31:0] ins_addr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        done;

  modport master (
    output mem_req, mem_addr, ins_valid, instruct, ins_addr, done,
    input  mem_rvalid, mem_rdata, ins_ready, redirect, redirect_pc
  );
  modport slave (
    input  mem_req, mem_addr, ins_valid, instruct, ins_addr, done,
    output mem_rvalid, mem_rdata, ins_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/riscv_fetch_buffer.sv
// Sequential instruction fetcher with a DEPTH-entry buffer, redirect flush and zero-word halt.
// Defining FETCH_STATS_EN adds saturating pop / redirect counters.
module riscv_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  riscv_fetch_buffer_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [15:0] stat_flushes
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP, HALT} state_t;

  state_t          state;
  logic [31:0]     pc_q   [DEPTH];
  logic [31:0]     word_q [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_n;
  logic [31:0]     fetch_pc, req_pc, issue_pc;
  logic            outst, busy_n, halt_n, push, pop, issue, head_vld;

  assign head_vld = (count != '0);
  assign outst    = (state == WAIT) || (state == DROP);
  // Still waiting after this edge: the response has not arrived yet.
  assign busy_n   = outst && !bus.mem_rvalid;
  assign halt_n   = !bus.redirect &&
                    ((state == HALT) || (state == WAIT && bus.mem_rvalid && bus.mem_rdata == 32'h0));
  assign push     = (state == WAIT) && bus.mem_rvalid && !bus.redirect;
  assign pop      = head_vld && bus.ins_ready && !bus.redirect;
  assign count_n  = bus.redirect ? '0 : count + CW'(push) - CW'(pop);
  // Issue on the edge that lands in IDLE, so a response is followed by a request the very next
  // cycle; the post-edge count must leave a slot free for the new request.
  assign issue    = !busy_n && !halt_n && (count_n < CW'(DEPTH));
  assign issue_pc = bus.redirect ? bus.redirect_pc : fetch_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      fetch_pc     <= RESET_PC;
      req_pc       <= '0;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
    end else begin
      bus.mem_req <= issue;
      if (issue) begin
        bus.mem_addr <= issue_pc;
        req_pc       <= issue_pc;
        fetch_pc     <= issue_pc + 32'd4;
        state        <= WAIT;
      end else if (bus.redirect) begin
        fetch_pc <= bus.redirect_pc;
        state    <= busy_n ? DROP : IDLE;
      end else if (halt_n) begin
        state <= HALT;
      end else if (outst && bus.mem_rvalid) begin
        state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        word_q[i] <= '0;
      end
    end else begin
      count <= count_n;
      if (bus.redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          pc_q[wr_ptr]   <= req_pc;
          word_q[wr_ptr] <= bus.mem_rdata;
          wr_ptr         <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign bus.ins_valid = head_vld;
  assign bus.instruct  = word_q[rd_ptr];
  assign bus.ins_addr  = pc_q[rd_ptr];
  assign bus.done      = head_vld && (word_q[rd_ptr] == 32'h0);

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetched <= '0;
      stat_flushes <= '0;
    end else begin
      if (pop && stat_fetched != '1)          stat_fetched <= stat_fetched + 1'b1;
      if (bus.redirect && stat_flushes != '1) stat_flushes <= stat_flushes + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_fetch_buffer.sv
// Scoreboard bench for riscv_fetch_buffer: random memory latency, core stalls and redirects
// against a stream model (sequential PCs from the last reset/redirect, ending at a zero word).
module tb_riscv_fetch_buffer;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;
  typedef struct { logic [31:0] addr; int lat; } mreq_t;

  logic clk, rst;
  riscv_fetch_buffer_if bus ();
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [15:0] stat_flushes;
`endif

  riscv_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_flushes(stat_flushes)
`endif
  );

  int errors = 0, checks = 0;
  // stimulus knobs
  int lat_mode = 0;        // <0: random latency 0..3, else fixed extra cycles
  int ready_mode = 1;      // 0: never ready, 1: ready, 2: random
  bit zero_en = 0;
  logic [31:0] zero_addr = '0;
  bit check_gap = 0;
  // scoreboard / model state
  ent_t        exp_ins[$];
  logic [31:0] exp_req[$];
  int          outst[$];
  mreq_t       pend[$];
  int epoch = 0, bufd = 0, req_cnt = 0, cyc = 0, last_req = 0;
  bit have_last = 0;
  int m_pops = 0, m_flushes = 0;

  initial begin clk = 0; forever #5 clk = ~clk; end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (zero_en && a == zero_addr) ? 32'h0 : a + 32'h100;
  endfunction

  // Expected stream after a reset/redirect: sequential words up to and including a zero word.
  function automatic void refill(input logic [31:0] pc);
    ent_t e;
    exp_ins.delete();
    exp_req.delete();
    for (int i = 0; i < 400; i++) begin
      e.pc = pc + 32'(4 * i);
      e.w  = mem_word(e.pc);
      exp_ins.push_back(e);
      exp_req.push_back(e.pc);
      if (e.w == 32'h0) break;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Memory: captures requests, answers in order after 1+lat cycles.
  initial begin
    mreq_t m;
    bus.mem_rvalid = 0;
    bus.mem_rdata  = 0;
    fork
      forever begin
        @(negedge clk);
        if (rst && bus.mem_req) begin
          m.addr = bus.mem_addr;
          m.lat  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
          pend.push_back(m);
        end
      end
      forever begin
        @(posedge clk); #1;
        bus.mem_rvalid = 0;
        if (!rst) pend.delete();
        else if (pend.size() > 0) begin
          if (pend[0].lat == 0) begin
            m = pend.pop_front();
            bus.mem_rvalid = 1;
            bus.mem_rdata  = mem_word(m.addr);
          end else pend[0].lat = pend[0].lat - 1;
        end
      end
    join
  end

  // Core: never pops the halt word.
  initial begin
    bus.ins_ready = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.ins_ready = 0;
        1:       bus.ins_ready = !bus.done;
        default: bus.ins_ready = $urandom_range(0, 1) && !bus.done;
      endcase
    end
  end

  // Monitor: compares current outputs, then applies the events the next edge will consume.
  initial begin
    ent_t e;
    int ep;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        refill(RESET_PC);
        outst.delete();
        bufd = 0; epoch++; req_cnt = 0; have_last = 0; m_pops = 0; m_flushes = 0;
      end else begin
`ifdef FETCH_STATS_EN
        chk("stat_fetched", stat_fetched, m_pops);
        chk("stat_flushes", 32'(stat_flushes), m_flushes);
`endif
        if (bus.mem_req) begin
          req_cnt++;
          if (exp_req.size() == 0) fail_now("req_unexpected");
          else chk("req_addr", bus.mem_addr, exp_req.pop_front());
          if (outst.size() != 0) fail_now("two_outstanding");
          outst.push_back(epoch);
          if (check_gap && have_last) chk("req_gap", cyc - last_req, 2);
          last_req = cyc; have_last = 1;
        end
        chk("ins_valid", bus.ins_valid, bufd > 0);
        if (bus.ins_valid) begin
          if (exp_ins.size() == 0) fail_now("head_unexpected");
          else begin
            e = exp_ins[0];
            chk("ins_addr", bus.ins_addr, e.pc);
            chk("instruct", bus.instruct, e.w);
            chk("done", bus.done, e.w == 32'h0);
          end
        end else chk("done_idle", bus.done, 0);
        if (bus.mem_rvalid) begin
          if (outst.size() == 0) fail_now("rvalid_without_request");
          else begin
            ep = outst.pop_front();
            if (ep == epoch && !bus.redirect) begin
              bufd++;
              if (bufd > DEPTH) fail_now("push_into_full");
            end
          end
        end
        if (bus.ins_valid && bus.ins_ready && !bus.redirect) begin
          if (exp_ins.size() > 0) void'(exp_ins.pop_front());
          bufd--; m_pops++;
        end
        if (bus.redirect) begin
          bufd = 0; epoch++; m_flushes++;
          refill(bus.redirect_pc);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_ins_valid", bus.ins_valid, 0);
    chk("rst_instruct", bus.instruct, 0);
    chk("rst_ins_addr", bus.ins_addr, 0);
    chk("rst_done", bus.done, 0);
`ifdef FETCH_STATS_EN
    chk("rst_stat_fetched", stat_fetched, 0);
    chk("rst_stat_flushes", 32'(stat_flushes), 0);
`endif
  endtask

  task automatic wait_req(input logic [31:0] addr, input bit any, output bit ok);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.mem_req && (any || bus.mem_addr == addr)) ok = 1;
    end
    if (!ok) fail_now("wait_req_timeout");
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    @(posedge clk); #1;
    bus.redirect = 1; bus.redirect_pc = pc;
    @(posedge clk); #1;
    bus.redirect = 0;
  endtask

  initial begin
    bit ok;
    rst = 1; bus.redirect = 0; bus.redirect_pc = 0;
    #2 rst = 0;
    #3 check_reset_outputs();

    // 1-cycle memory, core always ready: requests every 2 cycles
    check_gap = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    repeat (30) @(posedge clk);
    check_gap = 0;

    // core stalled: exactly DEPTH requests, then resume
    ready_mode = 0; do_reset();
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("stall_req_cnt", req_cnt, DEPTH);
    chk("stall_mem_req", bus.mem_req, 0);
    chk("stall_valid", bus.ins_valid, 1);
    chk("stall_addr", bus.ins_addr, 0);
    ready_mode = 1;
    repeat (12) @(posedge clk);
    chk("resume", req_cnt > DEPTH, 1);

    // zero word at C halts; redirect to 0x20 resumes
    zero_en = 1; zero_addr = 32'hC; do_reset();
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("halt_done", bus.done, 1);
    chk("halt_instruct", bus.instruct, 0);
    chk("halt_addr", bus.ins_addr, 32'hC);
    chk("halt_req_cnt", req_cnt, 4);
    @(posedge clk); #1;
    bus.redirect = 1; bus.redirect_pc = 32'h20; zero_en = 0;
    @(posedge clk); #1 bus.redirect = 0;
    @(negedge clk);
    chk("unhalt_done", bus.done, 0);
    chk("unhalt_req", bus.mem_req, 1);
    chk("unhalt_addr", bus.mem_addr, 32'h20);
    repeat (20) @(posedge clk);

    // redirect while the request for 8 is outstanding on a slow memory
    lat_mode = 3; do_reset();
    wait_req(32'h8, 0, ok);
    pulse_redirect(32'h40);
    repeat (40) @(posedge clk);

    // redirect in the same cycle as the response
    lat_mode = 0; do_reset();
    wait_req(0, 1, ok);
    pulse_redirect(32'h80);
    @(negedge clk);
    chk("same_cycle_req", bus.mem_req, 1);
    chk("same_cycle_addr", bus.mem_addr, 32'h80);
    chk("same_cycle_valid", bus.ins_valid, 0);
    repeat (10) @(posedge clk);

    // async reset mid-WAIT with 2 entries buffered
    ready_mode = 0; lat_mode = 1; do_reset();
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (req_cnt == 3) ok = 1;
    end
    if (!ok) fail_now("third_req_timeout");
    #3 rst = 0;
    #1 check_reset_outputs();
    @(posedge clk); @(posedge clk); #1 rst = 1;
    wait_req(0, 1, ok);
    chk("post_reset_addr", bus.mem_addr, RESET_PC);

    // random traffic
    ready_mode = 2; lat_mode = -1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      bus.redirect = 0;
      if ($urandom_range(0, 19) == 0) begin
        bus.redirect    = 1;
        bus.redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
        zero_en         = $urandom_range(0, 1);
        zero_addr       = bus.redirect_pc + 32'(4 * $urandom_range(0, 10));
      end
    end
    @(posedge clk); #1 bus.redirect = 0;
    repeat (20) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
